datamem_pipe: RTL and testbench

DATAMEM_PIPE -- requirements
Module: datamem_pipe

---
 rtl/datamem_pipe.sv | 129 ++++++++++++
 tb/tb_datamem_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/datamem_pipe.sv
// Single-port data memory with a request/response handshake and a 2-entry response FIFO.
// After reset the array is cleared one word per cycle before requests are accepted.
module datamem_pipe #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int BYTES  = DATA_W / 8;
  localparam int LANE_W = $clog2(BYTES);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'((64'd1 << LANE_W) - 64'd1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state;
  state_t            next_state;
  logic [IDX_W-1:0]  clr_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] word_addr;
  logic [IDX_W-1:0]  idx;
  logic              misaligned;
  logic              out_of_range;
  logic              req_err;
  logic              push;
  logic              pop;
  logic              wr_en;
  logic              clr_we;
  logic [DATA_W-1:0] push_data;

  logic [DATA_W-1:0] fifo_data [2];
  logic              fifo_err  [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;

  // Request decode: word index and the two error conditions.
  assign word_addr    = req_addr >> LANE_W;
  assign idx          = word_addr[IDX_W-1:0];
  assign misaligned   = |(req_addr & LANE_MASK);
  assign out_of_range = word_addr >= ADDR_W'(DEPTH);
  assign req_err      = misaligned | out_of_range;

  assign req_ready = (state == S_RUN) && (count < 2'd2);
  assign init_done = (state == S_RUN);
  assign push      = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;
  assign wr_en     = push && req_we && !req_err;
  assign clr_we    = (state == S_INIT) && rst_n;

  // Reads return the word as stored before the accepting edge.
  assign push_data = (req_we || req_err) ? '0 : mem[idx];

  assign rsp_valid = (count != 2'd0);
  assign rsp_rdata = rsp_valid ? fifo_data[rd_ptr] : '0;
  assign rsp_err   = rsp_valid && fifo_err[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_INIT;
      clr_idx <= '0;
    end else begin
      state <= next_state;
      if (state == S_INIT) clr_idx <= clr_idx + 1'b1;
    end
  end

  // NOTE: next_state gets a default before the case so no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      S_INIT:  if (clr_idx == IDX_W'(DEPTH - 1)) next_state = S_RUN;
      S_RUN:   next_state = S_RUN;
      default: next_state = S_INIT;
    endcase
  end

  // NOTE: the array has no reset; it is cleared by INIT, and clearing is held off while rst_n is low.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < BYTES; i++) begin
        if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: it is only visible while count is nonzero.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= push_data;
      fifo_err[wr_ptr]  <= req_err;
    end
  end

endmodule

// File: tb/tb_datamem_pipe.sv
// Self-checking bench for datamem_pipe: directed scenarios plus a randomized phase,
// all responses compared against a word-array/queue reference model.
module tb_datamem_pipe;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  datamem_pipe #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .init_done(init_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [DEPTH];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          lat_mode = 1'b0;
  bit          rand_rdy = 1'b0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    foreach (model_mem[i]) model_mem[i] = '0;
    exp_q.delete();
  endfunction

  // Reference behaviour: word index = addr/4, error if misaligned or beyond DEPTH words.
  function automatic void model_accept(input bit we, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    bit   err;
    int   w;
    err       = (addr % 4 != 0) || ((addr / 4) >= DEPTH);
    e.rdata   = '0;
    e.err     = err;
    e.acc_cyc = cyc;
    e.chk_lat = lat_mode;
    if (!err) begin
      w = int'(addr / 4);
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model_mem[w][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        e.rdata = model_mem[w];
      end
    end
    exp_q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output int waits);
    bit acc;
    acc       = 1'b0;
    waits     = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    while (!acc && waits < 64) begin
      @(negedge clk);
      if (req_ready) begin
        model_accept(we, addr, wdata, be);
        acc = 1'b1;
      end else begin
        waits++;
      end
      tick();
    end
    req_valid = 1'b0;
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int t;
    rand_rdy  = 1'b0;
    rsp_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      tick();
      t++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    check("drain_rsp_valid", 32'(rsp_valid), 32'd0);
  endtask

  task automatic wait_init();
    int t;
    bit bad_ready;
    t = 0;
    bad_ready = 1'b0;
    do begin
      if (req_ready) bad_ready = 1'b1;
      tick();
      t++;
    end while (!init_done && t < 400);
    check("init_cycles", 32'(t), 32'd128);
    check("ready_low_in_init", 32'(bad_ready), 32'd0);
  endtask

  // Response monitor: compares the head every cycle it is presented, pops when taken.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_rsp_valid", 32'd1, 32'd0);
      end else begin
        check("rsp_rdata", rsp_rdata, exp_q[0].rdata);
        check("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
        if (rsp_ready) begin
          if (exp_q[0].chk_lat) check("rsp_latency", 32'(cyc - exp_q[0].acc_cyc), 32'd1);
          last_rdata = rsp_rdata;
          last_err   = rsp_err;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int          w;
    logic [31:0] a;
    logic [31:0] d;

    model_reset();
    #1;
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_init_done", 32'(init_done), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_held_init_done", 32'(init_done), 32'd0);
    rst_n = 1'b1;
    wait_init();

    rsp_ready = 1'b1;
    issue(1'b0, 32'h10, '0, 4'h0, w);
    drain();
    check("first_read_data", last_rdata, 32'h0000_0000);
    check("first_read_err", 32'(last_err), 32'd0);

    issue(1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, w);
    issue(1'b0, 32'h8, '0, 4'h0, w);
    drain();
    check("full_write_read", last_rdata, 32'hDEAD_BEEF);
    issue(1'b1, 32'h8, 32'h0000_5500, 4'h2, w);
    issue(1'b0, 32'h8, '0, 4'h0, w);
    drain();
    check("lane1_write_read", last_rdata, 32'hDEAD_55EF);

    issue(1'b0, 32'h6, '0, 4'h0, w);
    drain();
    check("misaligned_err", 32'(last_err), 32'd1);
    check("misaligned_rdata", last_rdata, 32'd0);
    issue(1'b1, 32'h200, 32'hFFFF_FFFF, 4'hF, w);
    drain();
    check("out_of_range_err", 32'(last_err), 32'd1);
    issue(1'b0, 32'h0, '0, 4'h0, w);
    drain();
    check("word0_untouched", last_rdata, 32'd0);
    check("word0_err", 32'(last_err), 32'd0);

    rsp_ready = 1'b0;
    issue(1'b0, 32'h0, '0, 4'h0, w);
    check("bp_first_accept", 32'(w), 32'd0);
    issue(1'b0, 32'h4, '0, 4'h0, w);
    check("bp_second_accept", 32'(w), 32'd0);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h8;
    repeat (3) begin
      @(negedge clk);
      check("bp_ready_low", 32'(req_ready), 32'd0);
      check("bp_rsp_held", 32'(rsp_valid), 32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    issue(1'b0, 32'h8, '0, 4'h0, w);
    drain();
    check("bp_third_data", last_rdata, 32'hDEAD_55EF);

    lat_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = 32'(4 * (20 + i));
      d = $urandom;
      issue(1'b1, a, d, 4'hF, w);
      check("tput_write_accept", 32'(w), 32'd0);
      issue(1'b0, a, '0, 4'h0, w);
      check("tput_read_accept", 32'(w), 32'd0);
    end
    lat_mode = 1'b0;
    drain();

    rsp_ready = 1'b0;
    issue(1'b0, 32'h8, '0, 4'h0, w);
    issue(1'b0, 32'hC, '0, 4'h0, w);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    check("midrst_init_done", 32'(init_done), 32'd0);
    check("midrst_rsp_rdata", rsp_rdata, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    wait_init();
    issue(1'b0, 32'h8, '0, 4'h0, w);
    drain();
    check("reinit_word2", last_rdata, 32'd0);

    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'(4 * $urandom_range(0, 31) + $urandom_range(1, 3));
        1:       a = 32'(4 * $urandom_range(DEPTH, DEPTH + 200));
        default: a = 32'(4 * $urandom_range(0, 31));
      endcase
      issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), w);
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain();
    for (int i = 0; i < 32; i++) issue(1'b0, 32'(4 * i), '0, 4'h0, w);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
